cnt_run_sched: RTL and testbench
================================

// Module: cnt_run_sched
// PURPOSE
//  Round-robin scheduler sharing one loadable up-counter (pe/ce/d load-and-count
//  interface) among NREQ requesters. Each requester asks for a "run": load a start
//  value, then issue exactly run_len count enables. Sits between requesters and the
//  counter instance; drives its pe, ce and d, and reports completion or abort.
// PARAMETERS
//  NREQ  2  number of requesters (2..4)
//  DW    3  counter data width (width of d / start value)
//  LW    4  run-length width; max run = 2**LW-1 count enables
// PORTS
//  clk        in   1        clock, all state on posedge
//  rstn       in   1        synchronous active-low reset
//  req        in   NREQ     per-requester run request, held high until done/abort
//  start_val  in   NREQ*DW  start value; slot i = [i*DW +: DW]
//  run_len    in   NREQ*LW  run length; slot i = [i*LW +: LW]
//  hold       in   1        pause: suppresses ce during RUN, no progress
//  gnt        out  NREQ     one-hot grant, registered, high LOAD..DONE
//  busy       out  1        state != IDLE
//  done       out  NREQ     one-cycle pulse on granted bit when run completes
//  abort      out  1        one-cycle pulse when granted req drops mid-run
//  pe         out  1        counter parallel-load enable
//  ce         out  1        counter count enable
//  d          out  DW       counter load value
// BEHAVIOUR
//  - Reset (rstn=0 at posedge): state=IDLE, gnt=0, done=0, abort=0, d=0, rem=0,
//    rr pointer so req[0] has highest priority; pe=ce=busy=0. Overrides any run.
//  - FSM states IDLE, LOAD, RUN, DONE. pe=(state==LOAD); ce=(state==RUN)&&!hold
//    (combinational from state/hold, glitch-free w.r.t. clk). d = latched start.
//  - IDLE: if |req, winner = first set bit scanning from (last_gnt+1) mod NREQ
//    upward with wrap. Next edge: gnt=onehot(winner), latch start_val/run_len of
//    winner into d/len registers, state=LOAD. No req -> stay IDLE.
//  - LOAD (1 cycle): pe=1. Next edge: len==0 -> DONE; else rem=len, state=RUN.
//  - RUN: each cycle with ce=1 decrements rem; on the edge where ce=1 and rem==1
//    -> DONE. Exactly len ce pulses regardless of hold cycles.
//  - DONE (1 cycle): done[winner]=1, gnt still held. Next edge: gnt=0,
//    last_gnt=winner, state=IDLE. Requester may drop req during DONE.
//  - Abort: granted req low in LOAD or RUN -> next edge state=IDLE, gnt=0,
//    abort=1 for one cycle, no done pulse, last_gnt=winner. Aborted run's ce
//    pulses already issued are not undone. Non-granted req changes are ignored.
//  - Latency: req seen in IDLE at cycle 0 -> pe in cycle 1 -> first ce in cycle 2
//    -> done in cycle len+2 (no hold) -> IDLE cycle len+3, earliest next LOAD len+4.
//  - start_val/run_len sampled only at grant; later changes have no effect.
//  - Counter wrap is the counter's business; scheduler does no value compare.
//  - pe and ce are never high in the same cycle.
// TESTING
//  1 rstn=0 two cycles, req=all 1 -> gnt=0, pe=ce=busy=done=abort=0, d=0.
//  2 req[0], start=5, len=3 -> pe cycle1 d=5; ce cycles 2-4; counter 5,6,7,0;
//    done[0] cycle5; busy low cycle6.
//  3 req=2'b11 held, both len=1 -> grants 0,1,0,1 alternating; done matches gnt.
//  4 req[1], len=4, hold high cycles 3-5 -> exactly 4 ce pulses, done at cycle 9.
//  5 req[0], len=0 -> single pe pulse cycle1, no ce, done[0] cycle2.
//  6 req[0] dropped at 2nd RUN cycle -> abort pulse next cycle, no done, IDLE;
//    separately rstn=0 mid-RUN -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/cnt_run_sched_if.sv
// cnt_run_sched_if
//   Bundles the requester-side and counter-side signals of the shared counter
//   scheduler.
//   master : requesters drive req/start_val/run_len/hold and observe the results.
//   slave  : the scheduler drives grant/status and the counter pe/ce/d controls.
//   req        per-requester run request
//   start_val  packed start values, slot i = [i*DW +: DW]
//   run_len    packed run lengths, slot i = [i*LW +: LW]
//   hold       pause counting during a run
//   gnt/busy/done/abort  scheduler status
//   pe/ce/d    counter load enable, count enable, load value
interface cnt_run_sched_if #(
  parameter int NREQ = 2,
  parameter int DW   = 3,
  parameter int LW   = 4
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] start_val;
  logic [NREQ*LW-1:0] run_len;
  logic               hold;
  logic [NREQ-1:0]    gnt;
  logic               busy;
  logic [NREQ-1:0]    done;
  logic               abort;
  logic               pe;
  logic               ce;
  logic [DW-1:0]      d;

  modport master (
    output req, start_val, run_len, hold,
    input  gnt, busy, done, abort, pe, ce, d
  );

  modport slave (
    input  req, start_val, run_len, hold,
    output gnt, busy, done, abort, pe, ce, d
  );
endinterface

// File: rtl/cnt_run_sched.sv
// cnt_run_sched
//   Round-robin scheduler that shares one loadable up-counter among NREQ
//   requesters. A granted requester gets one load (pe) of its start value
//   followed by exactly run_len count enables (ce), then a done pulse.
//   Dropping the granted request mid-run ends the run with an abort pulse.
//   clk   clock, all state on posedge
//   rstn  synchronous active-low reset
//   bus   cnt_run_sched_if slave modport (requests, status, counter controls)
//
//   state | meaning
//   IDLE  | no run, arbitrating among requests
//   LOAD  | pe high, counter takes the latched start value
//   RUN   | ce high unless hold, rem counts remaining enables
//   DONE  | done pulse on the granted bit, grant still held
module cnt_run_sched #(
  parameter int NREQ = 2,
  parameter int DW   = 3,
  parameter int LW   = 4
) (
  input  logic            clk,
  input  logic            rstn,
  cnt_run_sched_if.slave  bus
);
  localparam int IW = (NREQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t          state;
  logic [IW-1:0]   last_gnt;
  logic [IW-1:0]   win;
  logic [IW-1:0]   nxt;
  logic            nxt_found;
  logic [LW-1:0]   len;
  logic [LW-1:0]   rem;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] done_q;
  logic            abort_q;
  logic [DW-1:0]   d_q;
  logic            granted_req;

  // First requester found scanning upward from the one after the last grant.
  always_comb begin
    nxt       = last_gnt;
    nxt_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!nxt_found && bus.req[(int'(last_gnt) + k) % NREQ]) begin
        nxt       = IW'((int'(last_gnt) + k) % NREQ);
        nxt_found = 1'b1;
      end
    end
  end

  assign granted_req = bus.req[win];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      last_gnt <= IW'(NREQ - 1);
      win      <= '0;
      len      <= '0;
      rem      <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      abort_q  <= 1'b0;
      d_q      <= '0;
    end else begin
      done_q  <= '0;
      abort_q <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            win   <= nxt;
            gnt_q <= NREQ'(1) << nxt;
            d_q   <= bus.start_val[nxt*DW +: DW];
            len   <= bus.run_len[nxt*LW +: LW];
            state <= LOAD;
          end
        end
        LOAD: begin
          if (!granted_req) begin
            state    <= IDLE;
            gnt_q    <= '0;
            abort_q  <= 1'b1;
            last_gnt <= win;
          end else if (len == '0) begin
            state  <= DONE;
            done_q <= gnt_q;
          end else begin
            rem   <= len;
            state <= RUN;
          end
        end
        RUN: begin
          if (!granted_req) begin
            state    <= IDLE;
            gnt_q    <= '0;
            abort_q  <= 1'b1;
            last_gnt <= win;
          end else if (!bus.hold) begin
            // This edge consumes one count enable.
            rem <= rem - 1'b1;
            if (rem == LW'(1)) begin
              state  <= DONE;
              done_q <= gnt_q;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          gnt_q    <= '0;
          last_gnt <= win;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.done  = done_q;
  assign bus.abort = abort_q;
  assign bus.d     = d_q;
  assign bus.busy  = (state != IDLE);
  assign bus.pe    = (state == LOAD);
  assign bus.ce    = (state == RUN) && !bus.hold;
endmodule

// File: tb/tb_cnt_run_sched.sv
// tb_cnt_run_sched
//   Scoreboard bench for cnt_run_sched: stimulus pushes the expected outcome of
//   each run (done/abort vector, enable count, final counter value, pe-to-event
//   latency); a negedge monitor models the counter and pops/compares on every
//   done or abort pulse.
module tb_cnt_run_sched;
  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cnt_run_sched_if #(.NREQ(2), .DW(3), .LW(4)) bus ();

  cnt_run_sched #(.NREQ(2), .DW(3), .LW(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    logic [1:0] done;
    logic       abort;
    int         ces;
    logic [2:0] cnt;
    int         lat;
  } exp_t;

  exp_t exp_q[$];

  logic [2:0] cnt_m = '0;
  int         ces_m = 0;
  int         pe_cyc = 0;

  task automatic check(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Monitor: models the counter and scores every completion/abort event.
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.pe || bus.ce) check("pe_ce_exclusive", int'(bus.pe && bus.ce), 0);
      if (bus.pe) begin
        cnt_m  = bus.d;
        ces_m  = 0;
        pe_cyc = cyc;
      end
      if (bus.ce) begin
        cnt_m = cnt_m + 3'd1;
        ces_m = ces_m + 1;
      end
      if (bus.done != 2'b00 || bus.abort) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("done_vec", int'(bus.done), int'(e.done));
          check("abort", int'(bus.abort), int'(e.abort));
          check("ce_count", ces_m, e.ces);
          check("counter_val", int'(cnt_m), int'(e.cnt));
          check("latency", cyc - pe_cyc, e.lat);
          check("gnt_at_event", int'(bus.gnt), int'(e.done));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] dn, input logic ab, input int ces,
                      input logic [2:0] cnt, input int lat);
    exp_t e;
    e.done = dn; e.abort = ab; e.ces = ces; e.cnt = cnt; e.lat = lat;
    exp_q.push_back(e);
  endtask

  // Waits for a done/abort pulse; optionally drops all requests in that cycle.
  task automatic wait_evt(input int maxc, input bit drop);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < maxc && !seen; n++) begin
      @(negedge clk);
      if (bus.done != 2'b00 || bus.abort) seen = 1'b1;
    end
    if (!seen) check("event_timeout", 0, 1);
    if (drop) bus.req = 2'b00;
  endtask

  initial begin
    rstn = 1'b0;
    bus.req = 2'b11;
    bus.start_val = {3'd7, 3'd7};
    bus.run_len = {4'd2, 4'd2};
    bus.hold = 1'b0;

    // 1: reset with both requests asserted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", int'(bus.gnt), 0);
    check("rst_pe", int'(bus.pe), 0);
    check("rst_ce", int'(bus.ce), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_abort", int'(bus.abort), 0);
    check("rst_d", int'(bus.d), 0);

    step();
    bus.req = 2'b00;
    rstn = 1'b1;
    step();

    // 2: req0 start 5 len 3 -> counter ends at 0, done 4 cycles after pe.
    bus.start_val = {3'd0, 3'd5};
    bus.run_len = {4'd0, 4'd3};
    bus.req = 2'b01;
    push(2'b01, 1'b0, 3, 3'd0, 4);
    wait_evt(20, 1'b1);
    @(negedge clk);
    check("busy_after_done", int'(bus.busy), 0);

    // 3: fresh reset, both requesting len 1 -> grants alternate 0,1,0,1.
    step();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    bus.start_val = {3'd6, 3'd2};
    bus.run_len = {4'd1, 4'd1};
    bus.req = 2'b11;
    push(2'b01, 1'b0, 1, 3'd3, 2);
    push(2'b10, 1'b0, 1, 3'd7, 2);
    push(2'b01, 1'b0, 1, 3'd3, 2);
    push(2'b10, 1'b0, 1, 3'd7, 2);
    wait_evt(20, 1'b0);
    wait_evt(20, 1'b0);
    wait_evt(20, 1'b0);
    wait_evt(20, 1'b1);

    // 4: req1 len 4 with hold in cycles 3-5 -> 4 ce, done at cycle 9.
    step();
    bus.start_val = {3'd1, 3'd0};
    bus.run_len = {4'd4, 4'd0};
    bus.req = 2'b10;
    push(2'b10, 1'b0, 4, 3'd5, 8);
    step();
    step();
    step();
    bus.hold = 1'b1;
    step();
    step();
    step();
    bus.hold = 1'b0;
    wait_evt(20, 1'b1);

    // 5: req0 len 0 -> pe only, done the next cycle.
    step();
    bus.start_val = {3'd0, 3'd3};
    bus.run_len = {4'd0, 4'd0};
    bus.req = 2'b01;
    push(2'b01, 1'b0, 0, 3'd3, 1);
    wait_evt(10, 1'b1);

    // 6a: req0 len 5 dropped in the 2nd RUN cycle -> abort after 2 ce.
    step();
    bus.start_val = {3'd0, 3'd0};
    bus.run_len = {4'd0, 4'd5};
    bus.req = 2'b01;
    push(2'b00, 1'b1, 2, 3'd2, 3);
    step();
    step();
    step();
    bus.req = 2'b00;
    wait_evt(10, 1'b0);
    @(negedge clk);
    check("abort_one_cycle", int'(bus.abort), 0);
    check("idle_after_abort", int'(bus.busy), 0);

    // 6b: reset asserted mid-run.
    step();
    bus.start_val = {3'd4, 3'd0};
    bus.run_len = {4'd6, 4'd0};
    bus.req = 2'b10;
    step();
    step();
    step();
    check("running_before_rst", int'(bus.ce), 1);
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_gnt", int'(bus.gnt), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_pe", int'(bus.pe), 0);
    check("midrst_ce", int'(bus.ce), 0);
    check("midrst_done", int'(bus.done), 0);
    check("midrst_abort", int'(bus.abort), 0);
    check("midrst_d", int'(bus.d), 0);

    bus.req = 2'b00;
    step();
    rstn = 1'b1;
    step();
    step();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
